// File: rtl/rare_clk_gate_ctrl.sv
// rare_clk_gate_ctrl: sequences gating of a core clock on a rarely used block.
//   A sleep request is honoured only after the core has been idle for IDLE_HOLD
//   consecutive cycles. While gated, the block counts gated cycles. Waking up
//   re-enables the clock at once and reports awake after WAKE_SETTLE+1 cycles.
// Ports:
//   clk_i        free-running, ungated clock (only clock of this block)
//   rst_i        asynchronous active-high reset
//   sleep_req_i  level request to gate the core clock
//   core_idle_i  core has no outstanding work
//   wake_i       wake source (interrupt / debug); wins over sleep_req_i
//   cnt_clr_i    synchronous clear of gated_cnt_o; wins over increment
//   clk_en_o     enable into the clock-gate cell (registered, glitch-free)
//   sleep_ack_o  core clock is gated
//   awake_o      core clock is enabled and settled
//   gated_cnt_o  saturating count of cycles spent gated
module rare_clk_gate_ctrl #(
    parameter int unsigned IDLE_HOLD   = 4,
    parameter int unsigned WAKE_SETTLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_req_i,
    input  logic        core_idle_i,
    input  logic        wake_i,
    input  logic        cnt_clr_i,
    output logic        clk_en_o,
    output logic        sleep_ack_o,
    output logic        awake_o,
    output logic [31:0] gated_cnt_o
);

    localparam int unsigned IDLE_W   = 8;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned CNT_W    = 32;

    localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_HOLD - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_SETTLE);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_clk_en;
    logic                r_sleep_ack;
    logic                r_awake;
    logic [CNT_W-1:0]    r_gated_cnt;

    // Sleep is only pursued when requested and no wake source is pending.
    logic w_want_sleep;
    assign w_want_sleep = sleep_req_i & ~wake_i;

    // Control FSM; outputs are registered so clk_en_o cannot glitch into the
    // downstream latch while clk_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_RUN;
            r_idle_cnt   <= '0;
            r_settle_cnt <= '0;
            r_clk_en     <= 1'b1;
            r_sleep_ack  <= 1'b0;
            r_awake      <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_want_sleep) begin
                        r_state    <= ST_DRAIN;
                        r_idle_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!w_want_sleep) begin
                        r_state    <= ST_RUN;
                        r_idle_cnt <= '0;
                    end else if (!core_idle_i) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_state     <= ST_SLEEP;
                        r_idle_cnt  <= '0;
                        r_clk_en    <= 1'b0;
                        r_sleep_ack <= 1'b1;
                        r_awake     <= 1'b0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    end
                end
                ST_SLEEP: begin
                    if (!w_want_sleep) begin
                        r_state      <= ST_WAKE;
                        r_settle_cnt <= '0;
                        r_clk_en     <= 1'b1;
                        r_sleep_ack  <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    // Requests are ignored until the clock has settled.
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state      <= ST_RUN;
                        r_settle_cnt <= '0;
                        r_awake      <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_clk_en <= 1'b1;
                    r_awake  <= 1'b1;
                end
            endcase
        end
    end

    // Gated-cycle counter: clear wins, otherwise saturating increment in SLEEP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gated_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_gated_cnt <= '0;
        end else if ((r_state == ST_SLEEP) && (r_gated_cnt != CNT_MAX)) begin
            r_gated_cnt <= r_gated_cnt + CNT_W'(1);
        end
    end

    assign clk_en_o    = r_clk_en;
    assign sleep_ack_o = r_sleep_ack;
    assign awake_o     = r_awake;
    assign gated_cnt_o = r_gated_cnt;

endmodule

// File: tb/tb_rare_clk_gate_ctrl.sv
// Directed bench for rare_clk_gate_ctrl with IDLE_HOLD=4, WAKE_SETTLE=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rare_clk_gate_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        sleep_req_i;
    logic        core_idle_i;
    logic        wake_i;
    logic        cnt_clr_i;
    logic        clk_en_o;
    logic        sleep_ack_o;
    logic        awake_o;
    logic [31:0] gated_cnt_o;

    int n_vec;
    int n_err;

    rare_clk_gate_ctrl #(
        .IDLE_HOLD   (4),
        .WAKE_SETTLE (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sleep_req_i (sleep_req_i),
        .core_idle_i (core_idle_i),
        .wake_i      (wake_i),
        .cnt_clr_i   (cnt_clr_i),
        .clk_en_o    (clk_en_o),
        .sleep_ack_o (sleep_ack_o),
        .awake_o     (awake_o),
        .gated_cnt_o (gated_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the three control flags together.
    task automatic chk_flags(input string tag, input logic en, input logic ack, input logic awk);
        chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(en));
        chk({tag, ".sleep_ack"}, 32'(sleep_ack_o), 32'(ack));
        chk({tag, ".awake"}, 32'(awake_o), 32'(awk));
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_i       = 1'b1;
        sleep_req_i = 1'b0;
        core_idle_i = 1'b0;
        wake_i      = 1'b0;
        cnt_clr_i   = 1'b0;

        // Reset values.
        #1;
        chk_flags("rst", 1'b1, 1'b0, 1'b1);
        chk("rst.cnt", gated_cnt_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;

        // sleep_req and wake together in RUN: stays running.
        sleep_req_i = 1'b1;
        wake_i      = 1'b1;
        core_idle_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_flags($sformatf("run_both%0d", i), 1'b1, 1'b0, 1'b1);
        end

        // Nominal sleep: edge 0 samples the request, SLEEP after edge 4.
        wake_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_flags($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_flags("sleep_entry", 1'b0, 1'b1, 1'b0);
        chk("sleep_entry.cnt", gated_cnt_o, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("sleep_cnt%0d", i), gated_cnt_o, 32'(i));
        end

        // Clear wins over increment while sleeping, then counting resumes.
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_in_sleep", gated_cnt_o, 32'd0);
        cnt_clr_i = 1'b0;
        tick();
        chk("cnt_resume1", gated_cnt_o, 32'd1);
        tick();
        chk("cnt_resume2", gated_cnt_o, 32'd2);

        // Saturation from a preloaded value near the top.
        force dut.r_gated_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_gated_cnt;
        tick();
        chk("sat0", gated_cnt_o, 32'hFFFF_FFFE);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("sat%0d", i), gated_cnt_o, 32'hFFFF_FFFF);
        end
        chk_flags("sat_flags", 1'b0, 1'b1, 1'b0);
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_after_sat", gated_cnt_o, 32'd0);
        cnt_clr_i = 1'b0;

        // One-cycle wake pulse: clock back next edge, awake 3 cycles later.
        wake_i = 1'b1;
        tick();
        chk_flags("wake_edge", 1'b1, 1'b0, 1'b0);
        chk("wake_edge.cnt", gated_cnt_o, 32'd1);
        wake_i = 1'b0;
        tick();
        chk_flags("settle1", 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("settle2", 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("awake", 1'b1, 1'b0, 1'b1);
        sleep_req_i = 1'b0;
        tick();
        chk("cnt_hold_run", gated_cnt_o, 32'd1);

        // sleep_req and wake together in DRAIN: back to RUN, drain restarts.
        sleep_req_i = 1'b1;
        tick();
        tick();
        tick();
        wake_i = 1'b1;
        tick();
        chk_flags("drain_abort", 1'b1, 1'b0, 1'b1);
        wake_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_flags($sformatf("redrain%0d", i), 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_flags("resleep", 1'b0, 1'b1, 1'b0);

        // Reset between edges mid-SLEEP takes effect immediately.
        #3;
        rst_i = 1'b1;
        #1;
        chk_flags("rst_mid_sleep", 1'b1, 1'b0, 1'b1);
        chk("rst_mid_sleep.cnt", gated_cnt_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk_flags("post_rst_run", 1'b1, 1'b0, 1'b1);

        // Idle glitch in DRAIN: idle count restarts, 4 idle edges to SLEEP.
        tick();
        tick();
        chk_flags("glitch_pre", 1'b1, 1'b0, 1'b1);
        core_idle_i = 1'b0;
        tick();
        chk_flags("glitch_low", 1'b1, 1'b0, 1'b1);
        core_idle_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flags($sformatf("glitch_drain%0d", i), 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_flags("glitch_sleep", 1'b0, 1'b1, 1'b0);

        // Dropping sleep_req also wakes.
        sleep_req_i = 1'b0;
        tick();
        chk_flags("req_drop_wake", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rare_clk_gate_ctrl.md
RARE_CLK_GATE_CTRL -- requirements
Module: rare_clk_gate_ctrl

Interface
REQ-001 SHALL provide parameter IDLE_HOLD, default 4, legal 1..255: consecutive idle cycles required before gating.
REQ-002 SHALL provide parameter WAKE_SETTLE, default 2, legal 0..15: extra cycles spent in WAKE before reporting awake.
REQ-003 SHALL have port clk_i, input, 1: free-running, ungated clock; the block's only clock.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sleep_req_i, input, 1: level request to gate the core clock.
REQ-006 SHALL have port core_idle_i, input, 1: core has no outstanding work.
REQ-007 SHALL have port wake_i, input, 1: wake source, e.g. interrupt pending or debug request.
REQ-008 SHALL have port cnt_clr_i, input, 1: synchronous clear of gated_cnt_o.
REQ-009 SHALL have port clk_en_o, output, 1: enable driven into the clock-gate cell's en_i.
REQ-010 SHALL have port sleep_ack_o, output, 1: core clock is gated.
REQ-011 SHALL have port awake_o, output, 1: core clock is enabled and settled.
REQ-012 SHALL have port gated_cnt_o, output, 32: count of cycles spent with the clock gated.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN, SLEEP and WAKE, with all outputs registered and changing only on the clk_i rising edge.
REQ-014 SHALL hold RUN while sleep_req_i=0 or wake_i=1, and go to DRAIN with idle_cnt=0 when sleep_req_i=1 and wake_i=0.
REQ-015 SHALL, in DRAIN: increment idle_cnt when core_idle_i=1; clear idle_cnt to 0 when core_idle_i=0.
REQ-016 SHALL go from DRAIN to SLEEP on the edge where core_idle_i=1 and idle_cnt=IDLE_HOLD-1, so SLEEP is entered IDLE_HOLD edges after the RUN edge that sampled the request (idle held throughout).
REQ-017 SHALL abort DRAIN back to RUN when wake_i=1 or sleep_req_i=0, with clk_en_o never deasserted during DRAIN.
REQ-018 SHALL, on the SLEEP-entry edge, set clk_en_o=0, sleep_ack_o=1 and awake_o=0.
REQ-019 SHALL, in SLEEP, increment gated_cnt_o by 1 every cycle, saturating at 0xFFFFFFFF with no wrap.
REQ-020 SHALL go from SLEEP to WAKE when wake_i=1 or sleep_req_i=0, setting clk_en_o=1 and sleep_ack_o=0 on that edge.
REQ-021 SHALL stay in WAKE for WAKE_SETTLE+1 cycles, then go to RUN with awake_o=1; sleep_req_i and wake_i are ignored in WAKE.
REQ-022 SHALL give wake_i priority over sleep_req_i in every state when both are asserted in the same cycle.
REQ-023 SHALL give cnt_clr_i priority over increment: gated_cnt_o=0 on the next edge even while in SLEEP.
REQ-024 SHALL never drive X or glitches on clk_en_o, because the downstream latch is transparent while clk_i is low.

Reset
REQ-025 SHALL, while rst_i=1, asynchronously force state=RUN, clk_en_o=1, sleep_ack_o=0, awake_o=1, gated_cnt_o=0, idle_cnt=0 and settle_cnt=0.
REQ-026 SHALL, when reset asserts mid-SLEEP, restore clk_en_o=1 immediately without waiting for a clock edge.
REQ-027 SHALL resume normal operation on the first rising edge after rst_i deasserts.

Verification
REQ-028 Nominal sleep: IDLE_HOLD=4, core_idle_i=1, sleep_req_i rises and is sampled at edge 0 -> clk_en_o=0 and sleep_ack_o=1 after edge 4; gated_cnt_o increments 1 per cycle.
REQ-029 Idle glitch: core_idle_i drops for 1 cycle at edge 2 of DRAIN -> idle_cnt restarts; SLEEP entered 4 edges after core_idle_i returns to 1; clk_en_o stays 1 until then.
REQ-030 Wake: in SLEEP, pulse wake_i for 1 cycle with WAKE_SETTLE=2 -> clk_en_o=1 on the next edge; awake_o=1 exactly 3 cycles later.
REQ-031 Simultaneous: sleep_req_i=1 and wake_i=1 in RUN -> remains in RUN, clk_en_o stays 1; in DRAIN, the same pair -> returns to RUN.
REQ-032 Counter: preload gated_cnt_o near 0xFFFFFFFE and sleep 5 cycles -> holds 0xFFFFFFFF; cnt_clr_i=1 during SLEEP -> 0 on the next edge, then counting resumes.
REQ-033 Reset: assert rst_i mid-SLEEP between edges -> clk_en_o=1, sleep_ack_o=0 and awake_o=1 immediately; after release, state is RUN.
